sequenciador_irrigacao: RTL and testbench

Registered actuator sequencer between the combinational irrigation decision logic and the physical drip valve, sprinkler pump, inlet valve and alarm lamp. Takes the level-free request signals (drip request, sprinkler request, inlet-valve request, alarm) and turns them into safe actuator drives:
- minimum on-time;
- a dead interval between any two actuator runs;
- immediate abort on alarm;
- a blinking alarm lamp.

---
 rtl/sequenciador_irrigacao.sv | 150 +++++++++++++++
 tb/tb_sequenciador_irrigacao.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_irrigacao.sv
// sequenciador_irrigacao
// Registered actuator sequencer sitting between the combinational irrigation
// decision logic and the physical actuators. It enforces a minimum on-time
// per run, a dead interval between runs, immediate abort on alarm and drives
// a blinking alarm lamp.
//
// Ports:
//   clock           system clock, rising edge active
//   reset           asynchronous, active-high; clears all state
//   gotejamentoReq  drip irrigation request
//   aspersaoReq     sprinkler request (wins over drip)
//   valvulaReq      inlet valve request
//   alarmeIn        alarm condition
//   gotejamento     drip valve drive
//   aspersao        sprinkler pump drive
//   valvulaEntrada  inlet valve drive (registered, alarm-gated)
//   alarmeLamp      blinking alarm lamp
//   estado          FSM state: 00 IDLE, 01 GOTEJ, 10 ASPERS, 11 DEAD
module sequenciador_irrigacao #(
  parameter int unsigned MIN_ON     = 8,
  parameter int unsigned DEAD_TIME  = 4,
  parameter int unsigned BLINK_HALF = 5,
  parameter int unsigned TW         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       gotejamentoReq,
  input  logic       aspersaoReq,
  input  logic       valvulaReq,
  input  logic       alarmeIn,
  output logic       gotejamento,
  output logic       aspersao,
  output logic       valvulaEntrada,
  output logic       alarmeLamp,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GOTEJ  = 2'b01,
    ASPERS = 2'b10,
    DEAD   = 2'b11
  } state_t;

  localparam logic [TW-1:0] ON_LAST    = TW'(MIN_ON - 1);
  localparam logic [TW-1:0] DEAD_LAST  = TW'(DEAD_TIME - 1);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;

  logic          alarm_q;
  logic [TW-1:0] blink_cnt;

  // Selection used both from IDLE and on the last dead cycle: alarm blocks
  // any start, sprinkler has priority over drip.
  function automatic state_t select_run(input logic alarm,
                                        input logic asp_req,
                                        input logic got_req);
    state_t s;
    if (alarm)        s = IDLE;
    else if (asp_req) s = ASPERS;
    else if (got_req) s = GOTEJ;
    else              s = IDLE;
    return s;
  endfunction

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        state_nxt = select_run(alarmeIn, aspersaoReq, gotejamentoReq);
      end
      GOTEJ: begin
        if (alarmeIn)
          state_nxt = DEAD;
        else if (timer >= ON_LAST && (!gotejamentoReq || aspersaoReq))
          state_nxt = DEAD;
      end
      ASPERS: begin
        if (alarmeIn)
          state_nxt = DEAD;
        else if (timer >= ON_LAST && (!aspersaoReq || gotejamentoReq))
          state_nxt = DEAD;
      end
      DEAD: begin
        // Alarm is ignored for the length of the dead interval; it only
        // matters through the selection at the last cycle.
        if (timer >= DEAD_LAST)
          state_nxt = select_run(alarmeIn, aspersaoReq, gotejamentoReq);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, state timer and actuator drives. Drives are registered from the
  // next state so they always match the registered estado.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      gotejamento <= 1'b0;
      aspersao    <= 1'b0;
    end else begin
      state       <= state_nxt;
      gotejamento <= (state_nxt == GOTEJ);
      aspersao    <= (state_nxt == ASPERS);
      if (state_nxt != state)
        timer <= '0;
      else if (timer != TIMER_MAX)
        timer <= timer + 1'b1;
    end
  end

  assign estado = state;

  // Inlet valve: independent of the irrigation FSM, cut by alarm.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      valvulaEntrada <= 1'b0;
    else
      valvulaEntrada <= valvulaReq & ~alarmeIn;
  end

  // Alarm lamp: alarm_q marks that the alarm was already seen, so the first
  // alarm cycle lights the lamp and starts the half-period count from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alarm_q    <= 1'b0;
      blink_cnt  <= '0;
      alarmeLamp <= 1'b0;
    end else if (!alarmeIn) begin
      alarm_q    <= 1'b0;
      blink_cnt  <= '0;
      alarmeLamp <= 1'b0;
    end else if (!alarm_q) begin
      alarm_q    <= 1'b1;
      blink_cnt  <= '0;
      alarmeLamp <= 1'b1;
    end else if (blink_cnt >= BLINK_LAST) begin
      blink_cnt  <= '0;
      alarmeLamp <= ~alarmeLamp;
    end else begin
      blink_cnt  <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sequenciador_irrigacao.sv
// Testbench for sequenciador_irrigacao with default parameters.
// Stimulus pushes the hand-computed output vector expected after the next
// clock edge into a queue; a monitor on the falling edge pops and compares.
// Vector layout: {estado[1:0], gotejamento, aspersao, valvulaEntrada, alarmeLamp}
module tb_sequenciador_irrigacao;

  logic       clock;
  logic       reset;
  logic       gotejamentoReq;
  logic       aspersaoReq;
  logic       valvulaReq;
  logic       alarmeIn;
  logic       gotejamento;
  logic       aspersao;
  logic       valvulaEntrada;
  logic       alarmeLamp;
  logic [1:0] estado;

  sequenciador_irrigacao #(
    .MIN_ON    (8),
    .DEAD_TIME (4),
    .BLINK_HALF(5),
    .TW        (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .gotejamentoReq(gotejamentoReq),
    .aspersaoReq   (aspersaoReq),
    .valvulaReq    (valvulaReq),
    .alarmeIn      (alarmeIn),
    .gotejamento   (gotejamento),
    .aspersao      (aspersao),
    .valvulaEntrada(valvulaEntrada),
    .alarmeLamp    (alarmeLamp),
    .estado        (estado)
  );

  typedef struct {
    int unsigned due;
    logic [5:0]  v;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  string       phase = "reset";

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [5:0] outs();
    return {estado, gotejamento, aspersao, valvulaEntrada, alarmeLamp};
  endfunction

  task automatic compare(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b (estado,got,asp,valv,lamp)", name, got, want);
    end
  endtask

  // Monitor: compares the entry due in the current cycle; stale entries fail.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d), expected %b",
               e.tag, e.due, cyc, e.v);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      compare($sformatf("%s cyc%0d", e.tag, e.due), outs(), e.v);
    end
  end

  function automatic logic [5:0] mk(input logic [1:0] st, input logic vl, input logic lp);
    return {st, st == 2'b01, st == 2'b10, vl, lp};
  endfunction

  task automatic push_exp(input int unsigned due, input logic [5:0] v);
    exp_t e;
    e.due = due;
    e.v   = v;
    e.tag = phase;
    q.push_back(e);
  endtask

  // Called just after a rising edge: apply inputs, expect the vector after
  // the next edge, then advance one cycle.
  task automatic run(input int n, input logic g, input logic a, input logic v,
                     input logic al, input logic [1:0] st, input logic vl,
                     input logic lp);
    for (int i = 0; i < n; i++) begin
      gotejamentoReq = g;
      aspersaoReq    = a;
      valvulaReq     = v;
      alarmeIn       = al;
      push_exp(cyc + 1, mk(st, vl, lp));
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    gotejamentoReq = 1'b0;
    aspersaoReq    = 1'b0;
    valvulaReq     = 1'b0;
    alarmeIn       = 1'b0;
    #22;
    compare("reset_state", outs(), 6'b000000);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    phase = "drip_pulse";
    run(1, 1, 0, 0, 0, 2'b01, 0, 0);
    run(7, 0, 0, 0, 0, 2'b01, 0, 0);
    run(4, 0, 0, 0, 0, 2'b11, 0, 0);
    run(2, 0, 0, 0, 0, 2'b00, 0, 0);

    phase = "held_sprinkler";
    run(20, 0, 1, 0, 0, 2'b10, 0, 0);
    run(4,  0, 0, 0, 0, 2'b11, 0, 0);
    run(1,  0, 0, 0, 0, 2'b00, 0, 0);

    phase = "alarm_abort";
    run(3, 1, 0, 0, 0, 2'b01, 0, 0);
    run(4, 1, 0, 0, 1, 2'b11, 0, 1);
    run(1, 1, 0, 0, 1, 2'b00, 0, 1);
    run(5, 1, 0, 0, 1, 2'b00, 0, 0);
    run(5, 1, 0, 0, 1, 2'b00, 0, 1);
    run(2, 0, 0, 0, 0, 2'b00, 0, 0);

    phase = "preempt";
    run(2, 1, 0, 0, 0, 2'b01, 0, 0);
    run(6, 1, 1, 0, 0, 2'b01, 0, 0);
    run(4, 1, 1, 0, 0, 2'b11, 0, 0);
    run(1, 1, 1, 0, 0, 2'b10, 0, 0);
    run(7, 0, 0, 0, 0, 2'b10, 0, 0);
    run(4, 0, 0, 0, 0, 2'b11, 0, 0);
    run(1, 0, 0, 0, 0, 2'b00, 0, 0);

    phase = "inlet_valve";
    run(2, 0, 0, 1, 0, 2'b00, 1, 0);
    run(2, 0, 0, 1, 1, 2'b00, 0, 1);
    run(2, 0, 0, 1, 0, 2'b00, 1, 0);
    run(1, 0, 0, 0, 0, 2'b00, 0, 0);

    phase = "async_reset";
    run(5, 0, 1, 0, 0, 2'b10, 0, 0);
    @(negedge clock);
    #1;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    compare("async_reset_immediate", outs(), 6'b000000);
    @(negedge clock);
    reset = 1'b0;
    phase = "after_reset";
    push_exp(cyc + 1, mk(2'b10, 0, 0));
    @(posedge clock);
    #1;
    run(7, 0, 0, 0, 0, 2'b10, 0, 0);
    run(4, 0, 0, 0, 0, 2'b11, 0, 0);
    run(1, 0, 0, 0, 0, 2'b00, 0, 0);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
